// File: rtl/cr_huf_comp_mc_sm_fifo_if.sv
// Bundle of the per-channel push/pop/status signals of the multi-channel small FIFO.
// The master side pushes and pops. The slave side is the FIFO itself.
interface cr_huf_comp_mc_sm_fifo_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 55,
    parameter int CW       = 3
);
    logic [CHANNELS-1:0]       wen;
    logic [CHANNELS-1:0]       ren;
    logic [CHANNELS-1:0]       clear;
    logic [CHANNELS*WIDTH-1:0] wdata;
    logic [CHANNELS*WIDTH-1:0] rdata;
    logic [CHANNELS*WIDTH-1:0] rdata_nxt;
    logic [CHANNELS-1:0]       empty;
    logic [CHANNELS-1:0]       full;
    logic [CHANNELS-1:0]       afull;
    logic [CHANNELS*CW-1:0]    used_slots;
    logic [CHANNELS*CW-1:0]    free_slots;
    logic [CHANNELS-1:0]       underflow;
    logic [CHANNELS-1:0]       overflow;

    modport master (
        output wen, ren, clear, wdata,
        input  rdata, rdata_nxt, empty, full, afull, used_slots, free_slots,
               underflow, overflow
    );

    modport slave (
        input  wen, ren, clear, wdata,
        output rdata, rdata_nxt, empty, full, afull, used_slots, free_slots,
               underflow, overflow
    );
endinterface

// File: rtl/cr_huf_comp_mc_sm_fifo.sv
// Multi-channel small FIFO for the huffman compressor datapaths.
// CHANNELS independent circular queues of DEPTH x WIDTH, each with a head view
// (rdata) and a head+1 lookahead (rdata_nxt). A push into a full queue is
// accepted when a pop is accepted in the same cycle. Underflow/overflow are
// registered one-cycle pulses.
// Optional feature macro: CR_HUF_COMP_MC_FIFO_BYPASS_EN. When it is defined, a
// simultaneous push+pop on an empty queue passes wdata straight to rdata
// without storing it.
module cr_huf_comp_mc_sm_fifo #(
    parameter int CHANNELS     = 2,
    parameter int DEPTH        = 6,
    parameter int WIDTH        = 55,
    parameter int AFULL_THRESH = 4,
    parameter int DATA_RESET   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    cr_huf_comp_mc_sm_fifo_if.slave       fifo_io
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Circular increment that works for any DEPTH, not only powers of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d, rptr_nxt_s;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic             uf_q, uf_d, of_q, of_d;
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic             wen_s, ren_s, clr_s;
        logic [WIDTH-1:0] wdata_s;
        logic             empty_s, full_s, rd_ok_s, wr_ok_s, byp_s, mem_we_s;

        assign wen_s   = fifo_io.wen[c];
        assign ren_s   = fifo_io.ren[c];
        assign clr_s   = fifo_io.clear[c];
        assign wdata_s = fifo_io.wdata[c*WIDTH +: WIDTH];

        assign empty_s = (cnt_q == {CW{1'b0}});
        assign full_s  = (cnt_q == CW'(DEPTH));

`ifdef CR_HUF_COMP_MC_FIFO_BYPASS_EN
        // Pass-through only on an empty queue with both requests, never during a flush.
        assign byp_s = empty_s & wen_s & ren_s & ~clr_s;
`else
        assign byp_s = 1'b0;
`endif

        assign rd_ok_s    = ren_s & ~empty_s;
        // A bypassed word is consumed on the spot, so it is not stored.
        assign wr_ok_s    = wen_s & (~full_s | rd_ok_s) & ~byp_s;
        // A flush leaves storage untouched, including any push in that cycle.
        assign mem_we_s   = wr_ok_s & ~clr_s;
        assign rptr_nxt_s = ptr_inc(rptr_q);

        // Next-state pointers, count and error pulses for this channel.
        always_comb begin
            rptr_d = rptr_q;
            wptr_d = wptr_q;
            cnt_d  = cnt_q;
            uf_d   = 1'b0;
            of_d   = 1'b0;
            if (clr_s) begin
                rptr_d = {PW{1'b0}};
                wptr_d = {PW{1'b0}};
                cnt_d  = {CW{1'b0}};
            end else begin
                if (rd_ok_s) begin
                    rptr_d = ptr_inc(rptr_q);
                end else begin
                    rptr_d = rptr_q;
                end
                if (wr_ok_s) begin
                    wptr_d = ptr_inc(wptr_q);
                end else begin
                    wptr_d = wptr_q;
                end
                if (rd_ok_s && !wr_ok_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (wr_ok_s && !rd_ok_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                uf_d = ren_s & empty_s & ~byp_s;
                of_d = wen_s & full_s & ~rd_ok_s;
            end
        end

        // Pointer, count and error-pulse registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rptr_q <= {PW{1'b0}};
                wptr_q <= {PW{1'b0}};
                cnt_q  <= {CW{1'b0}};
                uf_q   <= 1'b0;
                of_q   <= 1'b0;
            end else begin
                rptr_q <= rptr_d;
                wptr_q <= wptr_d;
                cnt_q  <= cnt_d;
                uf_q   <= uf_d;
                of_q   <= of_d;
            end
        end

        if (DATA_RESET != 0) begin : g_mem_rst
            // Storage write port, cleared by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= {WIDTH{1'b0}};
                    end
                end else if (mem_we_s) begin
                    mem_q[wptr_q] <= wdata_s;
                end
            end
        end else begin : g_mem_nrst
            // Storage write port. Contents are not reset.
            always_ff @(posedge clk) begin
                if (mem_we_s) begin
                    mem_q[wptr_q] <= wdata_s;
                end
            end
        end

        assign fifo_io.rdata[c*WIDTH +: WIDTH]     = byp_s ? wdata_s : mem_q[rptr_q];
        assign fifo_io.rdata_nxt[c*WIDTH +: WIDTH] = mem_q[rptr_nxt_s];
        assign fifo_io.empty[c]                    = empty_s;
        assign fifo_io.full[c]                     = full_s;
        assign fifo_io.afull[c]                    = (cnt_q >= CW'(AFULL_THRESH));
        assign fifo_io.used_slots[c*CW +: CW]      = cnt_q;
        assign fifo_io.free_slots[c*CW +: CW]      = CW'(DEPTH) - cnt_q;
        assign fifo_io.underflow[c]                = uf_q;
        assign fifo_io.overflow[c]                 = of_q;
    end
endmodule

// File: tb/tb_cr_huf_comp_mc_sm_fifo.sv
// Bench for the multi-channel small FIFO. dut_a uses the default configuration
// (2 channels, depth 6). dut_b has 1 channel, depth 5, afull threshold 3 and
// resettable storage. Both are checked every cycle against a queue-based model.
module tb_cr_huf_comp_mc_sm_fifo;
    localparam int W = 55;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cr_huf_comp_mc_sm_fifo_if #(.CHANNELS(2), .WIDTH(W), .CW(3)) ifa ();
    cr_huf_comp_mc_sm_fifo_if #(.CHANNELS(1), .WIDTH(W), .CW(3)) ifb ();

    cr_huf_comp_mc_sm_fifo #(.CHANNELS(2), .DEPTH(6), .WIDTH(W), .AFULL_THRESH(4), .DATA_RESET(0))
        dut_a (.clk(clk), .rst(rst), .fifo_io(ifa));
    cr_huf_comp_mc_sm_fifo #(.CHANNELS(1), .DEPTH(5), .WIDTH(W), .AFULL_THRESH(3), .DATA_RESET(1))
        dut_b (.clk(clk), .rst(rst), .fifo_io(ifb));

    int total = 0;
    int bad   = 0;
    logic [W-1:0] mq [3][$];
    int   dep [3] = '{6, 6, 5};
    int   th  [3] = '{4, 4, 3};
    logic euf [3];
    logic eof [3];
    bit   byp_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifa.wen = 2'b00; ifa.ren = 2'b00; ifa.clear = 2'b00; ifa.wdata = {(2*W){1'b0}};
        ifb.wen = 1'b0;  ifb.ren = 1'b0;  ifb.clear = 1'b0;  ifb.wdata = {W{1'b0}};
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            euf[k] = 1'b0;
            eof[k] = 1'b0;
        end
    endtask

    // One cycle of queue k: flush, pass-through, or pop-then-push with error flags.
    task automatic mdl(input int k, input logic w, input logic r, input logic cl, input logic [W-1:0] d);
        int n;
        bit rd;
        n = mq[k].size();
        euf[k] = 1'b0;
        eof[k] = 1'b0;
        if (cl) begin
            mq[k].delete();
        end else if (byp_en && n == 0 && w && r) begin
            n = 0;
        end else begin
            rd = r && n > 0;
            euf[k] = r && n == 0;
            eof[k] = w && n == dep[k] && !rd;
            if (rd) void'(mq[k].pop_front());
            if (w && (n < dep[k] || rd)) mq[k].push_back(d);
        end
    endtask

    task automatic chk_ch(input int k, input logic [2:0] used, input logic [2:0] free,
                          input logic emp, input logic ful, input logic af,
                          input logic uf, input logic of, input logic [W-1:0] rd,
                          input logic [W-1:0] rn);
        int n;
        n = mq[k].size();
        chk($sformatf("used%0d", k), used, n);
        chk($sformatf("free%0d", k), free, dep[k] - n);
        chk($sformatf("empty%0d", k), emp, n == 0);
        chk($sformatf("full%0d", k), ful, n == dep[k]);
        chk($sformatf("afull%0d", k), af, n >= th[k]);
        chk($sformatf("underflow%0d", k), uf, euf[k]);
        chk($sformatf("overflow%0d", k), of, eof[k]);
        if (n >= 1) chk($sformatf("rdata%0d", k), rd, mq[k][0]);
        if (n >= 2) chk($sformatf("rdata_nxt%0d", k), rn, mq[k][1]);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk_ch(k, ifa.used_slots[k*3 +: 3], ifa.free_slots[k*3 +: 3], ifa.empty[k],
                   ifa.full[k], ifa.afull[k], ifa.underflow[k], ifa.overflow[k],
                   ifa.rdata[k*W +: W], ifa.rdata_nxt[k*W +: W]);
        end
        chk_ch(2, ifb.used_slots, ifb.free_slots, ifb.empty[0], ifb.full[0], ifb.afull[0],
               ifb.underflow[0], ifb.overflow[0], ifb.rdata, ifb.rdata_nxt);
    endtask

    // Entered just after a rising edge with inputs applied; leaves just after the next edge.
    task automatic tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            if (byp_en && mq[k].size() == 0 && ifa.wen[k] && ifa.ren[k] && !ifa.clear[k]) begin
                chk("bypass_rdata", ifa.rdata[k*W +: W], ifa.wdata[k*W +: W]);
            end
        end
        if (byp_en && mq[2].size() == 0 && ifb.wen[0] && ifb.ren[0] && !ifb.clear[0]) begin
            chk("bypass_rdata_b", ifb.rdata, ifb.wdata);
        end
        for (int k = 0; k < 2; k++) begin
            mdl(k, ifa.wen[k], ifa.ren[k], ifa.clear[k], ifa.wdata[k*W +: W]);
        end
        mdl(2, ifb.wen[0], ifb.ren[0], ifb.clear[0], ifb.wdata);
        @(posedge clk);
        #1;
        check_all();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef CR_HUF_COMP_MC_FIFO_BYPASS_EN
        byp_en = 1'b1;
`else
        byp_en = 1'b0;
`endif
        idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        // Some traffic on every channel, then a reset in the middle of a push.
        for (int i = 0; i < 3; i++) begin
            ifa.wen = 2'b11;
            ifa.wdata = {W'(64'h20 + i), W'(64'h30 + i)};
            ifb.wen = 1'b1;
            ifb.wdata = W'(64'h40 + i);
            tick();
        end
        ifa.wen = 2'b11;
        ifb.wen = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_empty", ifa.empty, 2'b11);
        chk("rst_used", ifa.used_slots, 6'd0);
        chk("rst_free", ifa.free_slots, {3'd6, 3'd6});
        chk("rst_afull", ifa.afull, 2'b00);
        chk("rst_uf", ifa.underflow, 2'b00);
        chk("rst_of", ifa.overflow, 2'b00);
        chk("rst_rdata_b", ifb.rdata, {W{1'b0}});
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all();

        // Fill ch0 with 0x10..0x15, then one extra push that must be rejected.
        for (int i = 0; i < 6; i++) begin
            ifa.wen = 2'b01;
            ifa.wdata[W-1:0] = W'(64'h10 + i);
            tick();
        end
        chk("fill_rdata0", ifa.rdata[W-1:0], W'(64'h10));
        ifa.wen = 2'b01;
        ifa.wdata[W-1:0] = W'(64'h99);
        tick();
        chk("ovf_pulse", ifa.overflow[0], 1'b1);
        tick();
        chk("ovf_gone", ifa.overflow[0], 1'b0);

        // Push and pop together on the full queue, then drain it.
        ifa.wen = 2'b01;
        ifa.ren = 2'b01;
        ifa.wdata[W-1:0] = W'(64'h16);
        tick();
        chk("wfull_rdata", ifa.rdata[W-1:0], W'(64'h11));
        chk("wfull_nxt", ifa.rdata_nxt[W-1:0], W'(64'h12));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("drain%0d", i), ifa.rdata[W-1:0], W'(64'h11 + i));
            ifa.ren = 2'b01;
            tick();
        end

        // Underflow on empty ch1, then flush ch1 with a push in the same cycle.
        ifa.ren = 2'b10;
        tick();
        ifa.wen = 2'b10;
        ifa.wdata[2*W-1:W] = W'(64'h77);
        tick();
        ifa.wen = 2'b10;
        ifa.clear = 2'b10;
        ifa.wdata[2*W-1:W] = W'(64'h78);
        tick();

        // Push and pop together on empty ch0.
        ifa.wen = 2'b01;
        ifa.ren = 2'b01;
        ifa.wdata[W-1:0] = W'(64'hAB);
        tick();
        tick();

        // Interleaved push/pop on the depth-5 instance.
        for (int i = 0; i < 12; i++) begin
            ifb.wen = (i % 3) != 2;
            ifb.ren = (i % 2) == 1;
            ifb.wdata = W'({$urandom, $urandom});
            tick();
        end

        // Random traffic on all channels.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                ifa.wen[k] = ($urandom_range(0, 3) != 0);
                ifa.ren[k] = ($urandom_range(0, 1) != 0);
                ifa.clear[k] = ($urandom_range(0, 24) == 0);
            end
            ifa.wdata = (2*W)'({$urandom, $urandom, $urandom, $urandom});
            ifb.wen = ($urandom_range(0, 2) != 0);
            ifb.ren = ($urandom_range(0, 1) != 0);
            ifb.clear = ($urandom_range(0, 24) == 0);
            ifb.wdata = W'({$urandom, $urandom});
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
